sirv_expl_axi_mst: RTL and testbench

SIRV_EXPL_AXI_MST -- requirements
Module: sirv_expl_axi_mst

---
 rtl/sirv_expl_axi_mst.sv | 173 +++++++++++++++++
 tb/tb_sirv_expl_axi_mst.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sirv_expl_axi_mst.sv
// sirv_expl_axi_mst: ICB-to-AXI single-beat initiator, one outstanding; SIRV_EXPL_AXI_MST_TIMEOUT_EN adds a response timeout
module sirv_expl_axi_mst #(
    parameter int AW     = 32,
    parameter int DW     = 64,
    parameter int TO_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic            icb_cmd_read,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic [DW-1:0]   icb_rsp_rdata,
    output logic            icb_rsp_err,
    output logic            axi_arvalid,
    input  logic            axi_arready,
    output logic [AW-1:0]   axi_araddr,
    output logic [7:0]      axi_arlen,
    output logic [2:0]      axi_arsize,
    output logic [1:0]      axi_arburst,
    output logic            axi_arcache,
    output logic            axi_arprot,
    output logic            axi_arlock,
    output logic            axi_awvalid,
    input  logic            axi_awready,
    output logic [AW-1:0]   axi_awaddr,
    output logic [7:0]      axi_awlen,
    output logic [2:0]      axi_awsize,
    output logic [1:0]      axi_awburst,
    output logic            axi_awcache,
    output logic            axi_awprot,
    output logic            axi_awlock,
    output logic            axi_wvalid,
    input  logic            axi_wready,
    output logic [DW-1:0]   axi_wdata,
    output logic [DW/8-1:0] axi_wstrb,
    output logic            axi_wlast,
    input  logic            axi_rvalid,
    output logic            axi_rready,
    input  logic [DW-1:0]   axi_rdata,
    input  logic [1:0]      axi_rresp,
    input  logic            axi_rlast,
    input  logic            axi_bvalid,
    output logic            axi_bready,
    input  logic [1:0]      axi_bresp
);
`ifdef SIRV_EXPL_AXI_MST_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RSP, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RSP} state_t;
`endif
    state_t state, state_nx;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic [DW-1:0]   rdata;
    logic            err, aw_done, w_done, in_drain, to_hit, unused;
    logic            cmd_hs, aw_hs, w_hs, r_hs, b_hs;

    assign cmd_hs = icb_cmd_valid && icb_cmd_ready;
    assign aw_hs  = axi_awvalid && axi_awready;
    assign w_hs   = axi_wvalid && axi_wready;
    assign r_hs   = axi_rvalid && axi_rready;
    assign b_hs   = axi_bvalid && axi_bready;
    assign unused = axi_rlast | (TO_CYC == 0);

    assign axi_araddr    = addr;
    assign axi_awaddr    = addr;
    assign axi_wdata     = wdata;
    assign axi_wstrb     = wmask;
    assign axi_arlen     = 8'd0;
    assign axi_awlen     = 8'd0;
    assign axi_arsize    = 3'($clog2(DW / 8));
    assign axi_awsize    = 3'($clog2(DW / 8));
    assign axi_arburst   = 2'b01;
    assign axi_awburst   = 2'b01;
    assign axi_arcache   = 1'b0;
    assign axi_awcache   = 1'b0;
    assign axi_arprot    = 1'b0;
    assign axi_awprot    = 1'b0;
    assign axi_arlock    = 1'b0;
    assign axi_awlock    = 1'b0;
    assign axi_wlast     = 1'b1;
    assign icb_rsp_rdata = rdata;
    assign icb_rsp_err   = err;

`ifdef SIRV_EXPL_AXI_MST_TIMEOUT_EN
    logic [7:0] cnt;
    logic       pend, in_wait;
    assign in_wait  = state == RDATA || state == WRESP;
    assign in_drain = state == DRAIN;
    assign to_hit   = in_wait && cnt == 8'(TO_CYC - 1) && !r_hs && !b_hs;
    // Count cycles spent waiting for r/b; pend remembers a beat the slave still owes after a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            cnt <= in_wait ? cnt + 8'd1 : '0;
            if (to_hit) pend <= 1'b1;
            else if (in_drain && (r_hs || b_hs)) pend <= 1'b0;
        end
    end
`else
    assign in_drain = 1'b0;
    assign to_hit   = 1'b0;
`endif

    // Next state and channel handshake outputs, all decoded from state so they are glitch-free Moore signals
    always_comb begin
        state_nx      = state;
        icb_cmd_ready = state == IDLE;
        icb_rsp_valid = state == RSP;
        axi_arvalid   = state == RADDR;
        axi_awvalid   = state == WREQ && !aw_done;
        axi_wvalid    = state == WREQ && !w_done;
        axi_rready    = state == RDATA || in_drain;
        axi_bready    = state == WRESP || in_drain;
        case (state)
            IDLE:  if (icb_cmd_valid) state_nx = icb_cmd_read ? RADDR : WREQ;
            RADDR: if (axi_arready) state_nx = RDATA;
            RDATA: if (axi_rvalid || to_hit) state_nx = RSP;
            WREQ:  if ((aw_done || axi_awready) && (w_done || axi_wready)) state_nx = WRESP;
            WRESP: if (axi_bvalid || to_hit) state_nx = RSP;
`ifdef SIRV_EXPL_AXI_MST_TIMEOUT_EN
            RSP:   if (icb_rsp_ready) state_nx = pend ? DRAIN : IDLE;
            DRAIN: if (axi_rvalid || axi_bvalid) state_nx = IDLE;
`else
            RSP:   if (icb_rsp_ready) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // State register, captured command, per-channel write handshake flags and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            wdata   <= '0;
            wmask   <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (cmd_hs) begin
                addr    <= icb_cmd_addr;
                wdata   <= icb_cmd_wdata;
                wmask   <= icb_cmd_wmask;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (state == RDATA && r_hs) begin
                rdata <= axi_rdata;
                err   <= axi_rresp != 2'b00;
            end else if (state == WRESP && b_hs) begin
                rdata <= '0;
                err   <= axi_bresp != 2'b00;
            end else if (to_hit) begin
                rdata <= '0;
                err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sirv_expl_axi_mst.sv
// tb_sirv_expl_axi_mst: table-driven transactions against a scripted AXI slave, plus reset/stall/timeout sequences
module tb_sirv_expl_axi_mst;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read, icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_cmd_addr;
    logic [63:0] icb_cmd_wdata, icb_rsp_rdata;
    logic [7:0]  icb_cmd_wmask;
    logic        axi_arvalid, axi_arready, axi_arcache, axi_arprot, axi_arlock;
    logic [31:0] axi_araddr, axi_awaddr;
    logic [7:0]  axi_arlen, axi_awlen, axi_wstrb;
    logic [2:0]  axi_arsize, axi_awsize;
    logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
    logic        axi_awvalid, axi_awready, axi_awcache, axi_awprot, axi_awlock;
    logic        axi_wvalid, axi_wready, axi_wlast, axi_rvalid, axi_rready, axi_rlast, axi_bvalid, axi_bready;
    logic [63:0] axi_wdata, axi_rdata;

    always #5 clk = ~clk;

    sirv_expl_axi_mst #(.AW(32), .DW(64), .TO_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
        .icb_rsp_err(icb_rsp_err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_arlock(axi_arlock),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awlock(axi_awlock),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    int checks = 0, errors = 0;
    int nar = 0, naw = 0, nw = 0;
    logic [31:0] last_ar, last_aw;
    logic [63:0] last_wd;
    logic [7:0]  last_ws;

    // Observe every AXI address/data handshake at the clock edge
    always @(posedge clk) begin
        if (axi_arvalid && axi_arready) begin nar++; last_ar = axi_araddr; end
        if (axi_awvalid && axi_awready) begin naw++; last_aw = axi_awaddr; end
        if (axi_wvalid && axi_wready) begin nw++; last_wd = axi_wdata; last_ws = axi_wstrb; end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [7:0]  wm;
        int          adly, wdly, rdly, hold;
        logic [63:0] sd;
        logic [1:0]  resp;
        logic [63:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[6];

    task automatic run(input vec_t v);
        int a0, w0, ac, wc, rc, lat, k;
        bit stall_ok;
        logic [63:0] rd0;
        a0 = v.rd ? nar : naw;
        w0 = nw;
        icb_cmd_valid = 1'b1; icb_cmd_read = v.rd; icb_cmd_addr = v.addr;
        icb_cmd_wdata = v.wd; icb_cmd_wmask = v.wm;
        axi_rdata = v.sd; axi_rresp = v.resp; axi_bresp = v.resp;
        k = 0;
        while (!icb_cmd_ready && k < 20) begin @(negedge clk); k++; end
        chk("accept", icb_cmd_ready, 1);
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        ac = 0; wc = 0; rc = 0; lat = 0;
        for (int s = 1; s <= 100; s++) begin
            if (icb_rsp_valid) begin lat = s; break; end
            axi_arready = axi_arvalid && ac >= v.adly;
            axi_awready = axi_awvalid && ac >= v.adly;
            axi_wready  = axi_wvalid && wc >= v.wdly;
            axi_rvalid  = axi_rready && rc >= v.rdly;
            axi_bvalid  = axi_bready && rc >= v.rdly;
            if (axi_arvalid || axi_awvalid) ac++;
            if (axi_wvalid) wc++;
            if (axi_rready || axi_bready) rc++;
            @(negedge clk);
        end
        axi_arready = 0; axi_awready = 0; axi_wready = 0; axi_rvalid = 0; axi_bvalid = 0;
        chk("latency", lat, v.exp_lat);
        chk("rsp_rdata", icb_rsp_rdata, v.exp_rd);
        chk("rsp_err", icb_rsp_err, v.exp_err);
        stall_ok = 1'b1;
        rd0 = icb_rsp_rdata;
        icb_cmd_valid = v.hold > 0;
        icb_cmd_read = 1'b0;
        for (int s = 0; s < v.hold; s++) begin
            if (icb_cmd_ready || axi_arvalid || axi_awvalid || !icb_rsp_valid || icb_rsp_rdata !== rd0) stall_ok = 1'b0;
            @(negedge clk);
        end
        if (v.hold > 0) chk("stall", stall_ok, 1);
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        icb_rsp_ready = 1'b0;
        chk("back_idle", icb_cmd_ready && !icb_rsp_valid, 1);
        if (v.rd) begin
            chk("ar_count", nar - a0, 1);
            chk("araddr", last_ar, v.addr);
        end else begin
            chk("aw_count", naw - a0, 1);
            chk("w_count", nw - w0, 1);
            chk("awaddr", last_aw, v.addr);
            chk("wdata", last_wd, v.wd);
            chk("wstrb", last_ws, v.wm);
        end
    endtask

    initial begin
        int s;
        tbl[0] = '{1, 32'h1000_0008, 64'h0, 8'h00, 0, 0, 0, 0, 64'h1122334455667788, 2'b00, 64'h1122334455667788, 0, 3};
        tbl[1] = '{0, 32'h2000_0010, 64'hA5A5_0000_FFFF_0001, 8'h0F, 3, 0, 0, 0, 64'hFFFF, 2'b10, 64'h0, 1, 6};
        tbl[2] = '{1, 32'h0000_0040, 64'h0, 8'h00, 2, 0, 4, 5, 64'hDEADBEEF_CAFEF00D, 2'b11, 64'hDEADBEEF_CAFEF00D, 1, 9};
        tbl[3] = '{0, 32'h0000_0080, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2, 1, 0, 64'h1234, 2'b00, 64'h0, 0, 6};
        tbl[4] = '{0, 32'h0000_00C8, 64'h5555_AAAA_5555_AAAA, 8'hA5, 1, 1, 0, 0, 64'h0, 2'b01, 64'h0, 1, 4};
        tbl[5] = '{1, 32'hFFFF_FFF8, 64'h0, 8'h00, 0, 0, 2, 0, 64'h0, 2'b00, 64'h0, 0, 5};
        icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = 0; icb_cmd_wdata = 0; icb_cmd_wmask = 0;
        icb_rsp_ready = 0; axi_arready = 0; axi_awready = 0; axi_wready = 0;
        axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 1; axi_bvalid = 0; axi_bresp = 0;
        #12;
        chk("rst_cmd_ready", icb_cmd_ready, 1);
        chk("rst_valids", {icb_rsp_valid, axi_arvalid, axi_awvalid, axi_wvalid}, 0);
        chk("rst_readies", {axi_rready, axi_bready}, 0);
        chk("rst_rsp", {icb_rsp_err, icb_rsp_rdata}, 0);
        chk("rst_addr", {axi_araddr, axi_awaddr}, 0);
        chk("rst_wdata", axi_wdata, 0);
        chk("rst_wstrb", axi_wstrb, 0);
        chk("const_len_burst", {axi_arlen, axi_awlen, axi_arburst, axi_awburst}, 20'h0_0005);
        chk("const_size", {axi_arsize, axi_awsize}, 6'o33);
        chk("const_attr_last", {axi_arcache, axi_arprot, axi_arlock, axi_awcache, axi_awprot, axi_awlock, axi_wlast}, 7'b0000001);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) run(tbl[i]);
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = 32'h300;
        icb_cmd_wdata = 64'h77; icb_cmd_wmask = 8'h01;
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        chk("wreq_valids", {axi_awvalid, axi_wvalid}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {axi_awvalid, axi_wvalid}, 0);
        chk("rst_mid_cmd_ready", icb_cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_no_rsp", icb_rsp_valid, 0);
        @(negedge clk);
        run(tbl[0]);
`ifdef SIRV_EXPL_AXI_MST_TIMEOUT_EN
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h50;
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        s = 2;
        while (!icb_rsp_valid && s < 40) begin @(negedge clk); s++; end
        chk("to_latency", s, 18);
        chk("to_err", icb_rsp_err, 1);
        chk("to_rdata", icb_rsp_rdata, 0);
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        icb_rsp_ready = 1'b0;
        s++;
        chk("drain_rready", axi_rready, 1);
        chk("drain_cmd_ready", icb_cmd_ready, 0);
        while (s < 30) begin @(negedge clk); s++; end
        axi_rvalid = 1'b1;
        @(negedge clk);
        axi_rvalid = 1'b0;
        chk("drain_exit", icb_cmd_ready, 1);
        run(tbl[3]);
`else
        s = 0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
